// File: rtl/cpu_datapath_pkg.sv
// cpu_datapath_pkg: shared widths, opcode and phase encodings for the CPU datapath
package cpu_datapath_pkg;
  localparam int DWIDTH = 8;
  localparam int AWIDTH = 5;
  typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcodeT;
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } stateT;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU selecting the next accumulator value by opcode
module cpu_alu
  import cpu_datapath_pkg::*;
#(
  parameter int DWIDTH = cpu_datapath_pkg::DWIDTH
) (
  input  opcodeT            opcode,
  input  logic [DWIDTH-1:0] ac,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] result
);
  always_comb begin
    result = opcode == ADD ? ac + data_in :
             opcode == AND ? ac & data_in :
             opcode == XOR ? ac ^ data_in :
             opcode == LDA ? data_in : ac;
  end
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: PC/IR/AC registers, ALU and address mux driven by controller strobes
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int DWIDTH = cpu_datapath_pkg::DWIDTH,
  parameter int AWIDTH = cpu_datapath_pkg::AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadAc,
  input  logic              loadIr,
  input  logic              incPc,
  input  logic              loadPc,
  input  logic              halt,
  input  logic [DWIDTH-1:0] data_in,
  output opcodeT            opcode,
  output logic              zero,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] data_out,
  output logic [AWIDTH-1:0] pc,
  output logic              fetch,
  output logic              halted
);
  if (DWIDTH != 3 + AWIDTH) begin : g_width_check
    $error("cpu_datapath: DWIDTH must equal 3 + AWIDTH");
  end
  logic [DWIDTH-1:0] ir, ac, alu_result;
  stateT             phase;
  logic              run;
  // a halt request freezes state on the very edge it arrives, dropping its companion incPc
  assign run      = !halted && !halt;
  assign opcode   = opcodeT'(ir[DWIDTH-1:AWIDTH]);
  assign zero     = ac == '0;
  assign fetch    = phase < OP_ADDR;
  assign mem_addr = fetch ? pc : ir[AWIDTH-1:0];
  assign data_out = ac;
  cpu_alu #(.DWIDTH(DWIDTH)) u_alu (
    .opcode (opcode),
    .ac     (ac),
    .data_in(data_in),
    .result (alu_result)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      ir     <= '0;
      ac     <= '0;
      phase  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      if (halt) halted <= 1'b1;
      if (run) begin
        phase <= stateT'(phase + 3'd1);
        if (loadIr) ir <= data_in;
        // the STORE-phase loadAc would reapply ADD/AND/XOR, so only ALU_OP captures
        if (loadAc && phase == ALU_OP) ac <= alu_result;
        if (loadPc) pc <= ir[AWIDTH-1:0];
        else if (incPc) pc <= pc + AWIDTH'(1);
      end
    end
  end
endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath consumer of the CPU control FSM's strobes (loadAc, loadIr, incPc, loadPc, halt).
- Holds program counter (PC), instruction register (IR), accumulator (AC) and the ALU.
- Generates the memory address and write data, and returns opcode and zero to the controller.
- Keeps an internal 8-phase counter in lockstep with the controller so it can select fetch vs operand addressing without extra control wiring.

Parameters:
- DWIDTH, 8, data/instruction width; instruction = {opcode[2:0], addr[AWIDTH-1:0]}
- AWIDTH, 5, memory address width; DWIDTH = 3 + AWIDTH is required (elaboration error otherwise)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- loadAc  input  1  capture ALU result into AC
- loadIr  input  1  capture data_in into IR
- incPc  input  1  increment PC
- loadPc  input  1  load PC from IR address field
- halt  input  1  stop request (HLT decoded by controller)
- data_in  input  DWIDTH  memory read data
- opcode  output  opcodeT  IR[DWIDTH-1:AWIDTH]
- zero  output  1  high when AC == 0
- mem_addr  output  AWIDTH  memory address
- data_out  output  DWIDTH  memory write data (= AC)
- pc  output  AWIDTH  current PC (debug/trace)
- fetch  output  1  high during the four instruction-fetch phases
- halted  output  1  sticky halt indicator

Behaviour:
- Reset (async, rst=1): pc=0, ir=0 (opcode=HLT, addr=0), ac=0, phase=0, halted=0.
  - Outputs in reset: zero=1, fetch=1, mem_addr=0, data_out=0.
  - Reset deasserted mid-instruction restarts at phase 0; no partial state retained.
- Phase counter: 3-bit; +1 each clk, wraps 7->0. Phases 0..7 correspond to INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE. fetch = (phase < 4).
- mem_addr = fetch ? pc : ir[AWIDTH-1:0]. Combinational, valid in the same cycle.
- IR: loadIr=1 -> ir <= data_in at the clock edge (one-cycle latency). opcode and addr are combinational from ir.
- PC update:
  - loadPc has priority over incPc (both are asserted together in STORE for JMP): pc <= ir addr.
  - Otherwise incPc=1: pc <= pc+1 modulo 2^AWIDTH (31 -> 0).
  - Neither asserted: hold.
- ALU result, combinational from the current opcode:
  - ADD: ac + data_in, truncated to DWIDTH; carry discarded.
  - AND: ac & data_in.
  - XOR: ac ^ data_in.
  - LDA: data_in.
  - HLT/SKZ/STO/JMP: ac unchanged.
- AC: loadAc=1 -> ac <= ALU result. The controller asserts loadAc in both ALU_OP and STORE; the second load must yield the same value as the first, since data_in is stable for the instruction. Exception: ADD/AND/XOR applied twice.
- Decided fix for ADD/AND/XOR: AC captures on loadAc only when phase == 6 (ALU_OP). A loadAc in phase 7 is ignored.
- zero = (ac == 0), combinational, so SKZ sees AC as of the current instruction.
- data_out = ac at all times; the memory samples it on memWr.
- Halt:
  - halt=1 at a clock edge sets halted <= 1.
  - While halted=1: pc, ir, ac and phase hold their values; all strobes are ignored.
  - Only rst clears halted.
  - halt and incPc arrive together in OP_ADDR. The incPc in that same cycle is ignored: pc stays at HLT address + 1 is not applied, so pc holds the HLT address + 0.
- Simultaneous loadIr and loadAc in one cycle: both captured independently. The ALU uses the old opcode.

Decomposition:
- Shared package (typedefs): opcodeT (HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP=7), stateT phase encoding reused for the phase counter, DWIDTH/AWIDTH constants.
- One sub-module: cpu_alu. Combinational; inputs opcode, ac, data_in; output result.
- PC, IR, AC, phase counter and halt latch stay in cpu_datapath.

Test Plan:
- Reset then release, no strobes:
  - In reset: pc=0, ac=0, zero=1, fetch=1, mem_addr=0, halted=0.
  - fetch drops after 4 clocks and returns after 8.
- loadIr with data_in=8'h45 (ADD, addr 5), then in phase 6 loadAc with data_in=8'h03 and ac=8'hFE -> ac=8'h01 (carry dropped), zero=0. A repeated loadAc in phase 7 leaves ac=8'h01.
- pc=31, incPc pulse -> pc=0. With ir=8'hE9 (JMP 9), loadPc and incPc together -> pc=9.
- ir=8'hC3 (STO 3), non-fetch phase -> mem_addr=3, data_out=ac. In a fetch phase -> mem_addr=pc.
- LDA 8'h00 -> ac=0, zero=1. Then XOR with data_in=8'h5A -> ac=8'h5A, zero=0.
- halt pulse with incPc at pc=7 -> halted=1, pc stays 7, phase frozen. Further loadIr/loadAc have no effect. rst clears everything.
